// File: rtl/score_pkg.sv
// score_pkg: shared glyph geometry, the zero glyph and plotter state encoding
package score_pkg;

    localparam int GLYPH_W         = 6;
    localparam int GLYPH_H         = 5;
    localparam int NUM_DIGITS      = 3;
    localparam int GLYPH_BITS      = 30;
    localparam int SCORE_WORD_BITS = 90;

    // rows 4..0 of the decoder's "0"; row 0 sits in the low six bits
    localparam logic [GLYPH_BITS-1:0] ZERO_GLYPH = 30'b001100_010110_011010_010010_001100;

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

endpackage

// File: rtl/score_plotter_if.sv
// score_plotter_if: redraw request, glyph word and VGA pixel stream
interface score_plotter_if;
    import score_pkg::*;

    logic                       start;
    logic [SCORE_WORD_BITS-1:0] score_display;
    logic [7:0]                 x;
    logic [6:0]                 y;
    logic [2:0]                 colour;
    logic                       plot;
    logic                       busy;
    logic                       done;

    modport master (output start, score_display, input x, y, colour, plot, busy, done);
    modport slave  (input start, score_display, output x, y, colour, plot, busy, done);

endinterface

// File: rtl/score_plotter_scan.sv
// glyph_scan_counter: nested col/row/digit counter walking the score glyphs
module glyph_scan_counter
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [1:0] o_digit,
    output logic [2:0] o_row,
    output logic [2:0] o_col,
    output logic       o_last
);

    logic [1:0] r_digit;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       w_col_wrap;
    logic       w_row_wrap;
    logic       w_digit_wrap;

    assign w_col_wrap   = r_col == 3'(GLYPH_W - 1);
    assign w_row_wrap   = r_row == 3'(GLYPH_H - 1);
    assign w_digit_wrap = r_digit == 2'(NUM_DIGITS - 1);

    // col is innermost; its wrap steps row, and row's wrap steps digit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn || i_clr) begin
            r_digit <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_en) begin
            r_col <= w_col_wrap ? 3'd0 : r_col + 3'd1;
            if (w_col_wrap) begin
                r_row <= w_row_wrap ? 3'd0 : r_row + 3'd1;
                if (w_row_wrap)
                    r_digit <= w_digit_wrap ? 2'd0 : r_digit + 2'd1;
            end
        end
    end

    assign o_digit = r_digit;
    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_last  = w_col_wrap && w_row_wrap && w_digit_wrap;

endmodule

// File: rtl/score_plotter.sv
// score_plotter: draws the 3-digit glyph word into the VGA frame buffer, one pixel per clock
// Optional: define SCORE_PLOTTER_LEADING_BLANK_EN to blank leading zero digits.
module score_plotter
    import score_pkg::*;
#(
    parameter logic [7:0] X0          = 8'd4,
    parameter logic [6:0] Y0          = 7'd2,
    parameter int         DIGIT_PITCH = 6,
    parameter logic [2:0] FG_COLOUR   = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
)
(
    input  logic            clk,
    input  logic            resetn,
    score_plotter_if.slave  bus
);

    state_t                     r_state;
    state_t                     w_next;
    logic [SCORE_WORD_BITS-1:0] r_snap;
    logic [SCORE_WORD_BITS-1:0] w_src;
    logic                       r_tail;
    logic                       w_emit;
    logic                       w_last;
    logic                       w_bit;
    logic                       w_blank;
    logic [1:0]                 w_digit;
    logic [2:0]                 w_row;
    logic [2:0]                 w_col;
    logic [6:0]                 w_idx;
    logic [7:0]                 w_x;
    logic [6:0]                 w_y;
    logic [7:0]                 r_x;
    logic [6:0]                 r_y;
    logic [2:0]                 r_colour;
    logic                       r_plot;
    logic                       r_busy;
    logic                       r_done;

    // The counter holds the index of the next pixel to emit; it sits at 0 in IDLE
    glyph_scan_counter u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .i_clr   (r_state == FIN),
        .i_en    (w_emit),
        .o_digit (w_digit),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    // Next state, pixel emit and pixel value; the start edge reads the live word
    // because the snapshot is only being loaded on that same edge
    always_comb begin
        w_emit = (r_state == IDLE && bus.start) || (r_state == DRAW && !r_tail);
        w_next = r_state == IDLE ? (bus.start ? DRAW : IDLE) :
                 r_state == DRAW ? (r_tail ? FIN : DRAW) : IDLE;
        w_src  = r_state == IDLE ? bus.score_display : r_snap;
        w_idx  = 7'(GLYPH_BITS * w_digit + GLYPH_W * w_row + w_col);
        w_bit  = w_src[w_idx];
        w_x    = X0 + 8'(DIGIT_PITCH * w_digit) + 8'(w_col);
        w_y    = Y0 + 7'(w_row);
`ifdef SCORE_PLOTTER_LEADING_BLANK_EN
        w_blank = (w_digit == 2'd0 && w_src[GLYPH_BITS-1:0] == ZERO_GLYPH) ||
                  (w_digit == 2'd1 && w_src[GLYPH_BITS-1:0] == ZERO_GLYPH &&
                   w_src[2*GLYPH_BITS-1:GLYPH_BITS] == ZERO_GLYPH);
`else
        w_blank = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Snapshot, registered pixel outputs, and the flag marking the last pixel on screen
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_snap   <= '0;
            r_tail   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tail <= w_emit && w_last;
            r_plot <= w_emit;
            r_busy <= w_next == DRAW;
            r_done <= w_next == FIN;
            if (r_state == IDLE && bus.start)
                r_snap <= bus.score_display;
            if (w_emit) begin
                r_x      <= w_x;
                r_y      <= w_y;
                r_colour <= (w_bit && !w_blank) ? FG_COLOUR : BG_COLOUR;
            end
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_score_plotter.sv
// tb_score_plotter: probe table plus per-pixel scoreboard for score_plotter
module tb_score_plotter;
    import score_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    score_plotter_if bus();

    score_plotter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [89:0] w;
        int          p;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
    } vec_t;

    pix_t       q[$];
    vec_t       vt[12];
    logic [7:0] cx[90];
    logic [6:0] cy[90];
    logic [2:0] cc[90];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    function automatic pix_t model(input logic [89:0] w, input int p);
        pix_t m;
        int   d;
        int   r;
        int   c;
        logic bl;
        d  = p / 30;
        r  = (p % 30) / 6;
        c  = p % 6;
        bl = 1'b0;
`ifdef SCORE_PLOTTER_LEADING_BLANK_EN
        bl = (d == 0 && w[29:0] == ZERO_GLYPH) ||
             (d == 1 && w[29:0] == ZERO_GLYPH && w[59:30] == ZERO_GLYPH);
`endif
        m.x = 8'(4 + 6 * d + c);
        m.y = 7'(2 + r);
        m.c = (w[p] && !bl) ? 3'b111 : 3'b000;
        return m;
    endfunction

    // mode 0 plain, 1 word changes mid-draw, 2 start re-pulsed while busy/FIN, 3 reset at pixel 40
    task automatic draw(input logic [89:0] w, input int mode);
        pix_t e;
        @(negedge clk);
        bus.score_display = w;
        for (int p = 0; p < 90; p++) q.push_back(model(w, p));
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 91; cyc++) begin
            @(negedge clk);
            if (mode == 3 && cyc == 41) begin
                resetn = 1'b0;
                #1;
                chk("reset_abort", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
                q.delete();
                break;
            end
            if (cyc <= 90) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL queue_empty cycle=%0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("pix%0d", cyc - 1),
                        {11'd0, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour},
                        {11'd0, 3'b110, e.x, e.y, e.c});
                    cx[cyc-1] = bus.x;
                    cy[cyc-1] = bus.y;
                    cc[cyc-1] = bus.colour;
                end
            end else begin
                chk("fin", {29'd0, bus.plot, bus.busy, bus.done}, 32'd1);
            end
            if (mode == 1 && cyc == 10) bus.score_display = ~w;
            if (mode == 2) bus.start = (cyc == 6 || cyc == 90 || cyc == 91);
        end
    endtask

    initial begin
        logic [89:0] w_one;
        logic [89:0] w_all;
        logic [89:0] w_b30;
        logic [89:0] w_rnd;
        logic [29:0] seven;
        w_one = {60'd0, 6'b001110, 6'b000100, 6'b000100, 6'b000110, 6'b000100};
        w_all = '1;
        w_b30 = 90'd1 << 30;
        seven = {6'b000100, 6'b000100, 6'b001000, 6'b010000, 6'b011110};
        vt[0]  = '{w_one, 2,  8'd6,  7'd2, 3'b111};
        vt[1]  = '{w_one, 1,  8'd5,  7'd2, 3'b000};
        vt[2]  = '{w_one, 7,  8'd5,  7'd3, 3'b111};
        vt[3]  = '{w_one, 8,  8'd6,  7'd3, 3'b111};
        vt[4]  = '{w_one, 25, 8'd5,  7'd6, 3'b111};
        vt[5]  = '{w_one, 26, 8'd6,  7'd6, 3'b111};
        vt[6]  = '{w_one, 27, 8'd7,  7'd6, 3'b111};
        vt[7]  = '{w_one, 24, 8'd4,  7'd6, 3'b000};
        vt[8]  = '{w_all, 0,  8'd4,  7'd2, 3'b111};
        vt[9]  = '{w_all, 89, 8'd21, 7'd6, 3'b111};
        vt[10] = '{w_b30, 30, 8'd10, 7'd2, 3'b111};
        vt[11] = '{w_b30, 29, 8'd9,  7'd6, 3'b000};
        bus.start = 1'b0;
        bus.score_display = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {11'd0, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || vt[i].w !== vt[i-1].w) draw(vt[i].w, 0);
            chk($sformatf("probe%0d", i), {14'd0, cx[vt[i].p], cy[vt[i].p], cc[vt[i].p]},
                {14'd0, vt[i].x, vt[i].y, vt[i].c});
        end
        w_rnd = 90'({$urandom, $urandom, $urandom});
        draw(w_rnd, 1);
        w_rnd = 90'({$urandom, $urandom, $urandom});
        draw(w_rnd, 2);
        draw(~w_rnd, 0);
        draw(w_all, 3);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        end
        resetn = 1'b1;
        draw(w_one, 0);
        draw({seven, ZERO_GLYPH, ZERO_GLYPH}, 0);
        draw({ZERO_GLYPH, seven, ZERO_GLYPH}, 0);
        @(negedge clk);
        chk("idle_after", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_plotter.md
Name: score_plotter

Overview:
- Consumes the 90-bit glyph word produced by the score-to-display stage and writes the 3-digit score into the VGA frame buffer.
- Emits one pixel (x, y, colour, plot) per clock, in the same form the VGA adapter accepts.
- Snapshots the glyph word on start, so score updates during a draw never produce a torn digit.

Parameters:
- X0, 8'd4: x of the leftmost score column (hundreds digit, col 0).
- Y0, 7'd2: y of glyph row 0.
- DIGIT_PITCH, 6: x distance between digit origins.
- FG_COLOUR, 3'b111: colour for a set glyph bit.
- BG_COLOUR, 3'b000: colour for a clear glyph bit.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a redraw; sampled only in IDLE.
- score_display  in  90  glyph word: digit d at bits [30d+29:30d], d=0 hundreds (leftmost); row r at bits [6r+5:6r] within a digit, r=0 top; bit c is column c, c=0 leftmost.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel valid (VGA writeEn).
- busy  out  1  draw in progress.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; x, y, colour, plot, busy, done = 0; snapshot and counters cleared. Reset mid-draw aborts immediately, with no done pulse.
- States:
  - IDLE: start=1 at a clock edge latches score_display into the snapshot, clears digit/row/col to 0, sets busy=1, goes to DRAW. start=0 stays in IDLE.
  - DRAW: one pixel per cycle for exactly 90 cycles, then go to FIN.
  - FIN: exactly one cycle; done=1, busy=0, plot=0; then return to IDLE.
- All outputs are registered. The first pixel appears (plot=1) on the cycle after the start edge. plot stays high for 90 consecutive cycles.
- Scan order is digit-major, then row, then col:
  - col 0..5 is innermost;
  - col wraps 5→0 and increments row;
  - row wraps 4→0 and increments digit;
  - after digit 2, row 4, col 5, go to FIN.
- Per pixel:
  - x = X0 + DIGIT_PITCH*digit + col, computed in 8 bits; wrap modulo 256 is permitted and not flagged.
  - y = Y0 + row, in 7 bits.
  - colour = FG_COLOUR if snapshot bit [30*digit + 6*row + col] is 1, else BG_COLOUR.
- start while busy or in FIN is ignored; it is not queued.
- start held high continuously restarts a draw on each return to IDLE, i.e. one idle cycle between draws.
- Changes on score_display after the start edge have no effect until the next start.
- Latency: start edge → done pulse = 91 cycles; start-to-start minimum period = 92 cycles.

Optional Feature:
- Macro SCORE_PLOTTER_LEADING_BLANK_EN.
- Defined:
  - At start, if the hundreds digit slice equals ZERO_GLYPH, it is drawn entirely in BG_COLOUR.
  - If the hundreds digit is blank and the tens digit slice also equals ZERO_GLYPH, the tens digit is drawn in BG_COLOUR too.
  - The ones digit is never blanked.
  - Pixel count and timing are unchanged; blanked pixels still assert plot.
- Undefined: every digit is drawn from its glyph bits, including leading zeros.

Decomposition:
- Shared package score_pkg holds:
  - GLYPH_W=6, GLYPH_H=5, NUM_DIGITS=3, GLYPH_BITS=30, SCORE_WORD_BITS=90;
  - ZERO_GLYPH = 30'b001100_010110_011010_010010_001100, i.e. rows 4..0 of the decoder's "0";
  - state encoding IDLE/DRAW/FIN.
- One sub-module, glyph_scan_counter:
  - nested col/row/digit counter with clear and enable;
  - outputs the current indices plus a last flag at (2,4,5).
- score_plotter holds the FSM, the snapshot register, bit select, and the coordinate/colour registers.

Test Plan:
- Reset mid-draw: assert resetn=0 at pixel 40 → plot=0, busy=0 immediately; no done pulse; after release, IDLE and accepts start.
- All-ones word, start pulse → plot high for exactly 90 cycles, all colour=3'b111; first pixel (x=4, y=2); last pixel (x=4+12+5=21, y=6); done=1 on cycle 91 only.
- Digit-1 glyph in hundreds slice (row0=000100, row1=000110, row4=001110), others zero:
  - pixel (6,2) is FG, (5,2) is BG;
  - (5,3) and (6,3) are FG;
  - (5,6), (6,6), (7,6) are FG.
- Snapshot stability: start, then change score_display at pixel 10 → all 90 colours match the original word.
- start re-pulsed at pixels 5 and 89 and in the FIN cycle → ignored; exactly one done; a start 1 cycle after FIN begins a new draw.
- With SCORE_PLOTTER_LEADING_BLANK_EN, word for "007":
  - digits 0 and 1 all BG with plot=1;
  - digit 2 matches the "7" glyph;
  - for "070" only the hundreds digit is blanked.
